sq_sched: RTL and testbench

SQ_SCHED -- requirements
Module: sq_sched

---
 rtl/sq_sched.sv | 148 ++++++++++++++
 tb/tb_sq_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_sched.sv
// Two-requester integer square-root scheduler.
// A round-robin arbiter picks one signed operand at a time, and a bit-serial
// restoring square root resolves one result bit per cycle from the MSB down.
// Negative operands take the same number of cycles and report an error flag.
module sq_sched #(
  parameter int IW   = 27,
  parameter int OW   = 21,
  parameter int ITER = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [IW-1:0] din0,
  output logic          ack0,
  input  logic          req1,
  input  logic [IW-1:0] din1,
  output logic          ack1,
  output logic          busy,
  output logic [OW-1:0] dout,
  output logic          dout_vld,
  output logic          dout_id,
  output logic          dout_err
);

  // Counter must hold ITER-1; the product width must hold the full square of
  // an ITER-bit trial and also the whole operand magnitude.
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int SW = 2 * ITER;
  localparam int MW = (SW > IW) ? SW : IW;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   operand_q;
  logic            id_q;
  logic [CW-1:0]   cnt_q;
  logic [ITER-1:0] root_q;
  logic            lastGrant_q;
  logic            ack0_q;
  logic            ack1_q;
  logic            busy_q;
  logic [OW-1:0]   dout_q;
  logic            doutVld_q;
  logic            doutId_q;
  logic            doutErr_q;

  logic            anyReq;
  logic            grantOne;
  logic [ITER-1:0] bitMask;
  logic [ITER-1:0] trial;
  logic [MW-1:0]   trialWide;
  logic [MW-1:0]   trialSquare;
  logic [MW-1:0]   operandWide;
  logic [ITER-1:0] root_d;
  logic            isNeg;

  // Arbitration: a lone request wins outright; on a tie the requester that
  // was not granted last wins. lastGrant_q resets to 1 so requester 0 wins
  // the first tie.
  always_comb begin
    anyReq   = req0 | req1;
    grantOne = req1 & (~req0 | ~lastGrant_q);
  end

  // One restoring square-root step: try setting the current bit and keep it
  // only if the square of the trial still fits under the operand.
  always_comb begin
    bitMask     = ITER'(1) << cnt_q;
    trial       = root_q | bitMask;
    trialWide   = MW'(trial);
    trialSquare = trialWide * trialWide;
    operandWide = MW'(operand_q);
    isNeg       = operand_q[IW-1];
    root_d      = root_q;
    if (trialSquare <= operandWide) begin
      root_d = trial;
    end
  end

  // Control FSM with registered outputs: accept in IDLE, iterate in CALC,
  // publish the result on the edge that ends the final iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      operand_q   <= '0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      root_q      <= '0;
      lastGrant_q <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      dout_q      <= '0;
      doutVld_q   <= 1'b0;
      doutId_q    <= 1'b0;
      doutErr_q   <= 1'b0;
    end else begin
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      doutVld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (anyReq) begin
            operand_q   <= grantOne ? din1 : din0;
            id_q        <= grantOne;
            lastGrant_q <= grantOne;
            ack0_q      <= ~grantOne;
            ack1_q      <= grantOne;
            cnt_q       <= CW'(ITER - 1);
            root_q      <= '0;
            busy_q      <= 1'b1;
            state_q     <= CALC;
          end
        end
        CALC: begin
          root_q <= root_d;
          if (cnt_q == '0) begin
            dout_q    <= isNeg ? '0 : OW'(root_d);
            doutErr_q <= isNeg;
            doutId_q  <= id_q;
            doutVld_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign dout     = dout_q;
  assign dout_vld = doutVld_q;
  assign dout_id  = doutId_q;
  assign dout_err = doutErr_q;

endmodule

// File: tb/tb_sq_sched.sv
// Directed self-checking bench for sq_sched with default parameters.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_sq_sched;

  localparam int IW   = 27;
  localparam int OW   = 21;
  localparam int ITER = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0;
  logic [IW-1:0] din0;
  logic          ack0;
  logic          req1;
  logic [IW-1:0] din1;
  logic          ack1;
  logic          busy;
  logic [OW-1:0] dout;
  logic          dout_vld;
  logic          dout_id;
  logic          dout_err;

  int vectors = 0;
  int miscompares = 0;

  sq_sched #(.IW(IW), .OW(OW), .ITER(ITER)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .din0     (din0),
    .ack0     (ack0),
    .req1     (req1),
    .din1     (din1),
    .ack1     (ack1),
    .busy     (busy),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_id  (dout_id),
    .dout_err (dout_err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Issue one request, record what happens at the accept edge, then wait a
  // bounded number of cycles for the result. latency is -1 on timeout.
  task automatic runOp(input bit which, input logic [IW-1:0] value,
                       output logic ackOwn, output logic ackOther,
                       output logic busySeen, output int latency,
                       output logic [OW-1:0] res, output logic err,
                       output logic id);
    @(negedge clk);
    if (which) begin req1 = 1'b1; din1 = value; end
    else       begin req0 = 1'b1; din0 = value; end
    @(negedge clk);
    ackOwn   = which ? ack1 : ack0;
    ackOther = which ? ack0 : ack1;
    busySeen = busy;
    req0 = 1'b0;
    req1 = 1'b0;
    latency = -1;
    res = '0;
    err = 1'b0;
    id  = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (dout_vld) begin
        latency = n;
        res = dout;
        err = dout_err;
        id  = dout_id;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ack0, ack1, busy, dout, dout_vld, dout_id, dout_err} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got ack0=%b ack1=%b busy=%b dout=%0d vld=%b id=%b err=%b, want all 0",
               ack0, ack1, busy, dout, dout_vld, dout_id, dout_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic ao, ax, bs, er, id;
    int lat;
    logic [OW-1:0] r;
    runOp(1'b0, IW'(100), ao, ax, bs, lat, r, er, id);
    vectors++;
    if ({ao, ax, bs} !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL basic_accept: got ack0=%b ack1=%b busy=%b, want 1 0 1", ao, ax, bs);
    end
    vectors++;
    if (lat !== 13) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got %0d, want 13", lat);
    end
    vectors++;
    if ({r, id, er} !== {OW'(10), 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL basic_result: got dout=%0d id=%b err=%b, want 10 0 0", r, id, er);
    end
  endtask

  task automatic test_boundary;
    logic [IW-1:0] ins  [4] = '{IW'(67108863), IW'(0), IW'(99), IW'(1)};
    logic [OW-1:0] outs [4] = '{OW'(8191), OW'(0), OW'(9), OW'(1)};
    logic ao, ax, bs, er, id;
    int lat;
    logic [OW-1:0] r;
    for (int i = 0; i < 4; i++) begin
      runOp(1'b1, ins[i], ao, ax, bs, lat, r, er, id);
      vectors++;
      if (ao !== 1'b1 || ax !== 1'b0 || lat !== 13 || r !== outs[i] || id !== 1'b1 || er !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL boundary_%0d: din1=%0d got ack1=%b ack0=%b lat=%0d dout=%0d id=%b err=%b, want 1 0 13 %0d 1 0",
                 i, ins[i], ao, ax, lat, r, id, er, outs[i]);
      end
    end
  endtask

  task automatic test_negative;
    logic ao, ax, bs, er, id;
    int lat;
    logic [OW-1:0] r;
    logic signed [IW-1:0] neg;
    neg = -3;
    runOp(1'b0, neg, ao, ax, bs, lat, r, er, id);
    vectors++;
    if (lat !== 13) begin
      miscompares++;
      $display("[TB] FAIL negative_latency: got %0d, want 13", lat);
    end
    vectors++;
    if ({r, er, id} !== {OW'(0), 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL negative_result: got dout=%0d err=%b id=%b, want 0 1 0", r, er, id);
    end
  endtask

  task automatic test_round_robin;
    int grants [8];
    int gc = 0;
    int vt [4];
    logic [OW-1:0] vd [4];
    logic vi [4];
    int vc = 0;
    bit overlap = 1'b0;
    int expG [4] = '{0, 1, 0, 1};
    logic [OW-1:0] expD [4] = '{OW'(4), OW'(9), OW'(4), OW'(9)};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; din0 = IW'(16);
    req1 = 1'b1; din1 = IW'(81);
    for (int c = 0; c < 100 && vc < 4; c++) begin
      @(negedge clk);
      if (ack0 && ack1) overlap = 1'b1;
      if ((ack0 || ack1) && gc < 8) begin
        grants[gc] = ack1 ? 1 : 0;
        gc++;
      end
      if (dout_vld) begin
        vt[vc] = c; vd[vc] = dout; vi[vc] = dout_id;
        vc++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    vectors++;
    if (vc !== 4 || gc !== 4) begin
      miscompares++;
      $display("[TB] FAIL rr_count: got %0d results %0d grants, want 4 4", vc, gc);
    end
    vectors++;
    if (overlap !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rr_ack_overlap: got ack0 and ack1 together, want never");
    end
    for (int i = 0; i < 4; i++) begin
      if (i < gc) begin
        vectors++;
        if (grants[i] !== expG[i]) begin
          miscompares++;
          $display("[TB] FAIL rr_grant_%0d: got %0d, want %0d", i, grants[i], expG[i]);
        end
      end
      if (i < vc) begin
        vectors++;
        if (vd[i] !== expD[i] || vi[i] !== expG[i][0]) begin
          miscompares++;
          $display("[TB] FAIL rr_result_%0d: got dout=%0d id=%b, want %0d %0d", i, vd[i], vi[i], expD[i], expG[i]);
        end
      end
      if (i > 0 && i < vc) begin
        vectors++;
        if (vt[i] - vt[i-1] !== 14) begin
          miscompares++;
          $display("[TB] FAIL rr_spacing_%0d: got %0d cycles, want 14", i, vt[i] - vt[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_abort;
    int vldCount = 0;
    logic ao, ax, bs, er, id;
    int lat;
    logic [OW-1:0] r;
    @(negedge clk);
    req0 = 1'b1; din0 = IW'(10000);
    @(negedge clk);
    req0 = 1'b0;
    vectors++;
    if (ack0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_accept: got ack0=%b, want 1", ack0);
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, busy, dout, dout_vld, dout_id, dout_err} !== '0) begin
      miscompares++;
      $display("[TB] FAIL abort_outputs: got ack0=%b ack1=%b busy=%b dout=%0d vld=%b id=%b err=%b, want all 0",
               ack0, ack1, busy, dout, dout_vld, dout_id, dout_err);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dout_vld || ack0 || ack1) vldCount++;
    end
    vectors++;
    if (vldCount !== 0) begin
      miscompares++;
      $display("[TB] FAIL abort_no_result: got %0d vld/ack cycles, want 0", vldCount);
    end
    runOp(1'b1, IW'(49), ao, ax, bs, lat, r, er, id);
    vectors++;
    if (lat !== 13 || r !== OW'(7) || id !== 1'b1 || er !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_followup: got lat=%0d dout=%0d id=%b err=%b, want 13 7 1 0", lat, r, id, er);
    end
  endtask

  task automatic test_reset_release;
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b1; din0 = IW'(25);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    vectors++;
    if ({ack0, ack1, busy} !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL release_accept: got ack0=%b ack1=%b busy=%b, want 1 0 1", ack0, ack1, busy);
    end
    repeat (13) @(negedge clk);
    vectors++;
    if (dout_vld !== 1'b1 || dout !== OW'(5) || dout_id !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL release_result: got vld=%b dout=%0d id=%b, want 1 5 0", dout_vld, dout, dout_id);
    end
  endtask

  // Scenario sequence, then the summary.
  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;
    test_reset;
    test_basic;
    test_boundary;
    test_negative;
    test_round_robin;
    test_reset_abort;
    test_reset_release;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
